// File: rtl/data_sram_responder.sv
// Data-memory responder: one load/store at a time, stall for LATENCY cycles, then a one-cycle response.
// Optional out-of-range checking is compiled in with `define DSRAM_ADDR_CHECK_EN.
module data_sram_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [3:0]  req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rsp_rdata,
   output logic        rsp_valid,
   output logic        stall,
   output logic        addr_err
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [3:0]            wen_q;
   logic [31:0]           wdata_q;
   logic                  oor_q;
   logic [31:0]           rdata_q;
   logic                  valid_q;
   logic                  err_q;

   logic [31:0]           mem [DEPTH];

   logic [DEPTH_LOG2-1:0] idx_d;
   logic                  oor_d;
   logic                  commit_d;
   logic                  wr_en_d;

   assign idx_d = req_addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_ADDR_CHECK_EN
   logic unused_addr;
   assign oor_d       = |req_addr[31:DEPTH_LOG2+2];
   assign unused_addr = ^req_addr[1:0];
`else
   // Upper bits are dropped so the storage aliases across the address space.
   logic unused_addr;
   assign oor_d       = 1'b0;
   assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

   assign commit_d = (state_q == BUSY) && (cnt_q == 4'd0);
   assign wr_en_d  = commit_d && (wen_q != 4'b0000) && !oor_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wen_q   <= 4'b0000;
         wdata_q <= 32'd0;
         oor_q   <= 1'b0;
         rdata_q <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_en) begin
                  idx_q   <= idx_d;
                  wen_q   <= req_wen;
                  wdata_q <= req_wdata;
                  oor_q   <= oor_d;
                  cnt_q   <= CNT_INIT;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (wen_q == 4'b0000) begin
                     rdata_q <= oor_q ? 32'd0 : mem[idx_q];
                  end
                  valid_q <= 1'b1;
                  err_q   <= oor_q;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage is never reset; a reset before the commit cycle leaves it untouched.
   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         for (int i = 0; i < 4; i++) begin
            if (wen_q[i]) begin
               mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign stall     = ((state_q == IDLE) && req_en) || (state_q == BUSY);
   assign rsp_rdata = rdata_q;
   assign rsp_valid = valid_q;
   assign addr_err  = err_q;

endmodule
